// File: rtl/audio_mixer_pkg.sv
// Shared MSX audio package: fixed mix amplitudes, channel indices, mixer FSM
// states and the 16-bit saturation helpers used by the mixer and DC blocker.
package audio_mixer_pkg;

  localparam logic signed [23:0] KEYBEEP_AMP = 24'sh001000;
  localparam logic signed [23:0] TAPE_AMP    = 24'sh000800;

  localparam logic signed [23:0] SAT_MAX = 24'sd32767;
  localparam logic signed [23:0] SAT_MIN = -24'sd32768;

  typedef enum logic [1:0] {
    MIX_OPL3,
    MIX_SCC,
    MIX_PSG,
    MIX_AUX
  } mix_ch_e;

  // ST_DCB is only entered when the DC-blocking stage is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SAT,
    ST_DCB,
    ST_OUT
  } mix_state_e;

  function automatic logic [15:0] sat16(input logic signed [23:0] x);
    if (x > SAT_MAX)      return 16'h7fff;
    else if (x < SAT_MIN) return 16'h8000;
    else                  return x[15:0];
  endfunction

  function automatic logic is_clip(input logic signed [23:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

endpackage

// File: rtl/audio_dc_blocker.sv
// DC-blocking high-pass stage: y = x - x_prev + y_prev - (y_prev >>> 8).
// Filter state is 24-bit signed; the output is re-saturated to 16 bits and
// registered on each strobe. Only instantiated when AUDIO_MIXER_DCBLOCK_EN
// is defined.
module audio_dc_blocker
  import audio_mixer_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        strobe,
  input  logic [15:0] sample_in,
  output logic [15:0] sample_out,
  output logic        clip
);

  logic signed [23:0] x_prev;
  logic signed [23:0] y_prev;
  logic signed [23:0] x_ext;
  logic signed [23:0] y_next;

  // Next filter output from the current sample and the stored state.
  always_comb begin
    x_ext  = {{8{sample_in[15]}}, sample_in};
    y_next = x_ext - x_prev + y_prev - (y_prev >>> 8);
  end

  // Advance the filter state and register the saturated output on each strobe.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      x_prev     <= '0;
      y_prev     <= '0;
      sample_out <= '0;
      clip       <= 1'b0;
    end else if (strobe) begin
      x_prev     <= x_ext;
      y_prev     <= y_next;
      sample_out <= sat16(y_next);
      clip       <= is_clip(y_next);
    end
  end

endmodule

// File: rtl/audio_mixer.sv
// Paced, clip-safe audio mixer: snapshots all sources on ce_sample, sums the
// gain-scaled, mutable channels one per cycle on top of the key-beep and tape
// terms, saturates to 16 bits and registers the result.
// Optional feature: define AUDIO_MIXER_DCBLOCK_EN to insert a DC blocker
// between saturation and output (adds one cycle of latency).
module audio_mixer
  import audio_mixer_pkg::*;
#(
  parameter int CH    = 4,
  parameter int VOL_W = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ce_sample,
  input  logic [CH-1:0][15:0]      in_sound,
  input  logic [CH-1:0][VOL_W-1:0] vol,
  input  logic [CH-1:0]            mute,
  input  logic                     keybeep,
  input  logic                     tape_in,
  input  logic                     tape_monitor,
  output logic [15:0]              sound,
  output logic                     sound_valid,
  output logic                     clip,
  output logic                     overrun
);

  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW    = 16 + VOL_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH - 1);

  mix_state_e              state;
  logic [IDX_W-1:0]        idx;
  logic signed [23:0]      acc;
  logic [CH-1:0][15:0]     snap_sound;
  logic [CH-1:0][VOL_W-1:0] snap_vol;
  logic [CH-1:0]           snap_mute;

  logic [15:0]             cur_sound;
  logic [VOL_W-1:0]        cur_vol;
  logic                    cur_mute;
  logic signed [PW-1:0]    prod;
  logic signed [23:0]      term;
  logic signed [23:0]      preload;
  logic [15:0]             sat_value;
  logic                    sat_clip;

`ifdef AUDIO_MIXER_DCBLOCK_EN
  logic        clip_flag;
  logic [15:0] dcb_out;
  logic        dcb_clip;

  audio_dc_blocker u_dc_blocker (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .strobe     (state == ST_SAT),
    .sample_in  (sat_value),
    .sample_out (dcb_out),
    .clip       (dcb_clip)
  );
`endif

  // Scaled contribution of the current channel: (sample * vol) >>> 3, floored.
  always_comb begin
    cur_sound = snap_sound[idx];
    cur_vol   = snap_vol[idx];
    cur_mute  = snap_mute[idx];
    prod      = $signed({{(PW-16){cur_sound[15]}}, cur_sound}) *
                $signed({{(PW-VOL_W){1'b0}}, cur_vol});
    term      = cur_mute ? 24'sd0 : ($signed({{(24-PW){prod[PW-1]}}, prod}) >>> 3);
  end

  // Fixed key-beep/tape terms and the clamp of the finished accumulator.
  always_comb begin
    preload   = (keybeep ? KEYBEEP_AMP : 24'sd0) +
                ((tape_monitor && tape_in) ? TAPE_AMP : 24'sd0);
    sat_value = sat16(acc);
    sat_clip  = is_clip(acc);
  end

  // A strobe is only taken in IDLE; anywhere else it is flagged immediately.
  assign overrun = ce_sample && (state != ST_IDLE);

  // Mixer sequencer: snapshot, per-channel accumulate, saturate, publish.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      acc         <= '0;
      snap_sound  <= '0;
      snap_vol    <= '0;
      snap_mute   <= '0;
      sound       <= '0;
      sound_valid <= 1'b0;
      clip        <= 1'b0;
`ifdef AUDIO_MIXER_DCBLOCK_EN
      clip_flag   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          sound_valid <= 1'b0;
          clip        <= 1'b0;
          if (ce_sample) begin
            snap_sound <= in_sound;
            snap_vol   <= vol;
            snap_mute  <= mute;
            acc        <= preload;
            idx        <= '0;
            state      <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc <= acc + term;
          if (idx == LAST_IDX) state <= ST_SAT;
          else                 idx   <= idx + IDX_W'(1);
        end
        ST_SAT: begin
`ifdef AUDIO_MIXER_DCBLOCK_EN
          clip_flag   <= sat_clip;
          state       <= ST_DCB;
`else
          sound       <= sat_value;
          clip        <= sat_clip;
          sound_valid <= 1'b1;
          state       <= ST_OUT;
`endif
        end
        ST_DCB: begin
`ifdef AUDIO_MIXER_DCBLOCK_EN
          sound       <= dcb_out;
          clip        <= clip_flag | dcb_clip;
          sound_valid <= 1'b1;
          state       <= ST_OUT;
`else
          state       <= ST_IDLE;
`endif
        end
        ST_OUT: begin
          sound_valid <= 1'b0;
          clip        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer: directed literal cases plus randomized
// traffic, all checked every cycle against a timeline/arithmetic model.
module tb_audio_mixer;

`ifdef AUDIO_MIXER_DCBLOCK_EN
  localparam int LAT     = 7;
  localparam int SPACING = 8;
`else
  localparam int LAT     = 6;
  localparam int SPACING = 7;
`endif

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic             ce_sample = 1'b0;
  logic [3:0][15:0] in_sound = '0;
  logic [3:0][3:0]  vol      = '0;
  logic [3:0]       mute     = '0;
  logic             keybeep = 1'b0;
  logic             tape_in = 1'b0;
  logic             tape_monitor = 1'b0;
  logic [15:0]      sound;
  logic             sound_valid;
  logic             clip;
  logic             overrun;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int strobe_cyc = 0;

  audio_mixer #(.CH(4), .VOL_W(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_sample    (ce_sample),
    .in_sound     (in_sound),
    .vol          (vol),
    .mute         (mute),
    .keybeep      (keybeep),
    .tape_in      (tape_in),
    .tape_monitor (tape_monitor),
    .sound        (sound),
    .sound_valid  (sound_valid),
    .clip         (clip),
    .overrun      (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic longint floordiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void clamp16(input longint x, output int val, output bit clp);
    if (x > 32767)       begin val = 32767;  clp = 1'b1; end
    else if (x < -32768) begin val = -32768; clp = 1'b1; end
    else                 begin val = int'(x); clp = 1'b0; end
  endfunction

  // Mixed sample from the rules: fixed terms plus floor(sample*vol/8) per live channel.
  function automatic void mix_model(input logic [3:0][15:0] s, input logic [3:0][3:0] v,
                                    input logic [3:0] m, input logic kb, input logic ti,
                                    input logic tm, output longint sum);
    longint p;
    sum = 0;
    if (kb) sum += 4096;
    if (tm && ti) sum += 2048;
    for (int i = 0; i < 4; i++) begin
      if (!m[i]) begin
        p = longint'($signed(s[i])) * longint'(v[i]);
        sum += floordiv(p, 8);
      end
    end
  endfunction

  typedef struct {
    int due;
    int val;
    bit clp;
  } exp_t;

  exp_t   expq[$];
  int     last_acc = -1000;
  int     exp_sound = 0;
  longint xp = 0;
  longint yp = 0;
  bit     m_ovr, m_valid, m_clip;

  // Reference timeline: acceptance, overrun and output timing, checked every cycle.
  always @(negedge clk_sys) begin
    exp_t   e;
    longint sum;
    int     v;
    bit     c;
`ifdef AUDIO_MIXER_DCBLOCK_EN
    longint y;
    int     v2;
    bit     c2;
`endif
    m_ovr = 1'b0; m_valid = 1'b0; m_clip = 1'b0;
    if (reset) begin
      expq.delete();
      exp_sound = 0;
      last_acc  = -1000;
      xp = 0;
      yp = 0;
    end else begin
      if (ce_sample) begin
        if (cyc - last_acc >= SPACING) begin
          last_acc = cyc;
          mix_model(in_sound, vol, mute, keybeep, tape_in, tape_monitor, sum);
          clamp16(sum, v, c);
`ifdef AUDIO_MIXER_DCBLOCK_EN
          y  = longint'(v) - xp + yp - floordiv(yp, 256);
          xp = longint'(v);
          yp = y;
          clamp16(y, v2, c2);
          v = v2;
          c = c | c2;
`endif
          e.due = cyc + LAT;
          e.val = v;
          e.clp = c;
          expq.push_back(e);
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        m_valid   = 1'b1;
        exp_sound = expq[0].val;
        m_clip    = expq[0].clp;
        void'(expq.pop_front());
      end
    end
    check("mon_overrun", int'(overrun), int'(m_ovr));
    check("mon_valid", int'(sound_valid), int'(m_valid));
    check("mon_sound", int'($signed(sound)), exp_sound);
    check("mon_clip", int'(clip), int'(m_clip));
  end

  task automatic applyStimulus(input logic [3:0][15:0] s, input logic [3:0][3:0] v,
                               input logic [3:0] m, input logic kb, input logic ti,
                               input logic tm);
    @(posedge clk_sys); #1;
    in_sound = s; vol = v; mute = m;
    keybeep = kb; tape_in = ti; tape_monitor = tm;
    ce_sample = 1'b1;
    strobe_cyc = cyc;
    @(posedge clk_sys); #1;
    ce_sample = 1'b0;
  endtask

  task automatic checkOutput(input int exp_val, input bit exp_clp, input string name);
    int waited = 0;
    bit seen = 0;
    while (!seen && waited < 30) begin
      @(negedge clk_sys);
      if (sound_valid) seen = 1;
      else waited++;
    end
    if (!seen) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_latency"}, cyc - strobe_cyc, LAT);
      check({name, "_sound"}, int'($signed(sound)), exp_val);
      check({name, "_clip"}, int'(clip), int'(exp_clp));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nvalid;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset_sound", int'(sound), 0);
    check("reset_valid", int'(sound_valid), 0);
    check("reset_clip", int'(clip), 0);
    check("reset_overrun", int'(overrun), 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;

    // ch0 = 1000 at unity gain, others muted
    applyStimulus({16'd0, 16'd0, 16'd0, 16'd1000}, {4'd0, 4'd0, 4'd0, 4'd8},
                  4'b1110, 1'b0, 1'b0, 1'b0);
    checkOutput(1000, 1'b0, "unity");

`ifndef AUDIO_MIXER_DCBLOCK_EN
    applyStimulus({4{16'd20000}}, {4{4'd8}}, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput(32767, 1'b1, "clip_pos");
    applyStimulus({4{16'hB1E0}}, {4{4'd8}}, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput(-32768, 1'b1, "clip_neg");
    applyStimulus({16'd0, 16'd0, 16'hFFFD, 16'd0}, {4'd0, 4'd0, 4'd15, 4'd0},
                  4'b1101, 1'b0, 1'b0, 1'b0);
    checkOutput(-6, 1'b0, "floor_neg");
    applyStimulus({4{16'd1234}}, {4{4'd8}}, 4'b1111, 1'b1, 1'b1, 1'b1);
    checkOutput(6144, 1'b0, "beep_tape");

    // second strobe two cycles later must be ignored
    applyStimulus({16'd0, 16'd500, 16'd0, 16'd0}, {4'd0, 4'd8, 4'd0, 4'd0},
                  4'b1011, 1'b0, 1'b0, 1'b0);
    @(posedge clk_sys); #1;
    in_sound = {16'd0, 16'd7000, 16'd0, 16'd0};
    ce_sample = 1'b1;
    @(negedge clk_sys);
    check("overrun_pulse", int'(overrun), 1);
    @(posedge clk_sys); #1;
    ce_sample = 1'b0;
    checkOutput(500, 1'b0, "overrun_keep");
`endif

    // reset in the middle of a sample aborts it
    applyStimulus({16'd0, 16'd0, 16'd0, 16'd1234}, {4'd0, 4'd0, 4'd0, 4'd8},
                  4'b1110, 1'b0, 1'b0, 1'b0);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    reset = 1'b1;
    @(negedge clk_sys);
    check("midreset_sound", int'(sound), 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    nvalid = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (sound_valid) nvalid++;
    end
    check("midreset_no_valid", nvalid, 0);
    applyStimulus({16'd0, 16'd0, 16'd0, 16'hFB2E}, {4'd0, 4'd0, 4'd0, 4'd8},
                  4'b1110, 1'b0, 1'b0, 1'b0);
    checkOutput(-1234, 1'b0, "after_reset");

    // randomized traffic, including strobes closer than the minimum spacing
    for (int n = 0; n < 600; n++) begin
      @(posedge clk_sys); #1;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) in_sound[i] = $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
        else                           in_sound[i] = 16'($urandom);
        vol[i] = 4'($urandom_range(0, 15));
      end
      mute         = 4'($urandom) & 4'($urandom);
      keybeep      = 1'($urandom);
      tape_in      = 1'($urandom);
      tape_monitor = 1'($urandom);
      ce_sample    = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk_sys); #1;
    ce_sample = 1'b0;
    repeat (15) @(posedge clk_sys);
    @(negedge clk_sys);
    check("queue_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
